// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache: controller states,
// default geometry and bus word-addressing constants.
package icache_direct_pkg;

  localparam int ICD_SETS_DEF   = 16;
  localparam int ICD_WORDS_DEF  = 4;

  // Bus addresses are byte addresses of 32-bit words.
  localparam int ICD_WORD_BYTES = 4;
  localparam int ICD_BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } icd_state_e;

endpackage

// File: rtl/icache_direct_array.sv
// Tag and data storage for the cache: one combinational read port, one write port.
// Kept separate so it can be swapped for an SRAM macro; contents are never reset.
module icache_direct_array #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 24,
  parameter int IDX_W  = 4,
  parameter int WSEL_W = 2
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [WSEL_W-1:0] rd_word_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  input  logic              wr_data_en_i,
  input  logic              wr_tag_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WSEL_W-1:0] wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [TAG_W-1:0]  wr_tag_i
);

  localparam int LINES = 1 << IDX_W;
  localparam int DEPTH = 1 << (IDX_W + WSEL_W);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [LINES];

  always_ff @(posedge clk) begin
    if (wr_data_en_i) begin
      data_mem[{wr_idx_i, wr_word_i}] <= wr_data_i;
    end
    if (wr_tag_en_i) begin
      tag_mem[wr_idx_i] <= wr_tag_i;
    end
  end

  assign rd_data_o = data_mem[{rd_idx_i, rd_word_i}];
  assign rd_tag_o  = tag_mem[rd_idx_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with whole-line refill over a
// single-beat bus, fence.i invalidate-all, and hit/miss performance counters.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = ICD_SETS_DEF,
  parameter int WORDS  = ICD_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  input  logic              fence_i,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  output logic [ADDR_W-1:0] bus_araddr_o,
  output logic              bus_arvalid_o,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  // SETS and WORDS are expected to be powers of two, at least 2.
  localparam int WSEL_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int OFF_W  = WSEL_W + ICD_BYTE_OFF_W;
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  icd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WSEL_W-1:0] beat_q, beat_d;
  logic              fenced_q, fenced_d;
  logic              dropped_q, dropped_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  req_idx, lat_idx, rd_idx;
  logic [TAG_W-1:0]  req_tag, lat_tag, rd_tag;
  logic [WSEL_W-1:0] lat_word;
  logic [DATA_W-1:0] rd_data;
  logic              lookup_hit;
  logic              last_beat;
  logic              wr_data_en, wr_tag_en, set_valid;
  logic              unused_addr_bits;

  assign req_idx  = ifu_araddr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag  = ifu_araddr[ADDR_W-1:OFF_W+IDX_W];
  assign lat_idx  = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign lat_tag  = addr_q[ADDR_W-1:OFF_W+IDX_W];
  assign lat_word = addr_q[OFF_W-1:ICD_BYTE_OFF_W];
  assign unused_addr_bits = ^{ifu_araddr[ICD_BYTE_OFF_W-1:0], ifu_araddr[OFF_W-1:ICD_BYTE_OFF_W],
                              addr_q[ICD_BYTE_OFF_W-1:0]};

  // The single read port looks up the incoming request in IDLE and serves the
  // latched address otherwise.
  assign rd_idx = (state_q == IDLE) ? req_idx : lat_idx;

  icache_direct_array #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .WSEL_W (WSEL_W)
  ) u_array (
    .clk          (clk),
    .rd_idx_i     (rd_idx),
    .rd_word_i    (lat_word),
    .rd_data_o    (rd_data),
    .rd_tag_o     (rd_tag),
    .wr_data_en_i (wr_data_en),
    .wr_tag_en_i  (wr_tag_en),
    .wr_idx_i     (lat_idx),
    .wr_word_i    (beat_q),
    .wr_data_i    (bus_rdata),
    .wr_tag_i     (lat_tag)
  );

  // A fence arriving with the request wins: the lookup is forced to miss.
  assign lookup_hit = valid_q[req_idx] && (rd_tag == req_tag) && !fence_i;
  assign last_beat  = (beat_q == WSEL_W'(WORDS - 1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    fenced_d   = fenced_q;
    dropped_d  = dropped_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wr_data_en = 1'b0;
    wr_tag_en  = 1'b0;
    set_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ifu_arvalid) begin
          addr_d = ifu_araddr;
          if (lookup_hit) begin
            state_d   = RESP;
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            state_d    = FILL;
            beat_d     = '0;
            fenced_d   = 1'b0;
            dropped_d  = 1'b0;
            miss_cnt_d = miss_cnt_q + 32'd1;
          end
        end
      end

      FILL: begin
        if (fence_i) begin
          fenced_d = 1'b1;
        end
        if (!ifu_arvalid) begin
          dropped_d = 1'b1;
        end
        if (bus_rvalid && !rst) begin
          wr_data_en = 1'b1;
          if (last_beat) begin
            // The line is committed only if no fence landed during its fill.
            wr_tag_en = 1'b1;
            set_valid = !(fenced_q || fence_i);
            beat_d    = '0;
            state_d   = (dropped_q || !ifu_arvalid) ? IDLE : RESP;
          end else begin
            beat_d = beat_q + WSEL_W'(1);
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_valid
      assign valid_d[gi] = !fence_i &&
                           (valid_q[gi] || (set_valid && (lat_idx == IDX_W'(gi))));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      fenced_q   <= 1'b0;
      dropped_q  <= 1'b0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      fenced_q   <= fenced_d;
      dropped_q  <= dropped_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Outputs are gated by rst so they read zero in the reset cycle itself.
  assign ifu_rvalid_o  = (state_q == RESP) && !rst;
  assign ifu_rdata_o   = ifu_rvalid_o ? rd_data : '0;
  assign bus_arvalid_o = (state_q == FILL) && !rst;
  assign bus_araddr_o  = bus_arvalid_o ?
                         {addr_q[ADDR_W-1:OFF_W], beat_q, ICD_BYTE_OFF_W'(0)} : '0;
  assign hit_cnt_o     = rst ? 32'd0 : hit_cnt_q;
  assign miss_cnt_o    = rst ? 32'd0 : miss_cnt_q;

endmodule

// File: doc/icache_direct.md
ICACHE_DIRECT -- requirements
Module: icache_direct

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameter SETS, default 16, number of lines (power of 2).
REQ-004 SHALL have parameter WORDS, default 4, words per line (power of 2).
REQ-005 SHALL have port clk  in  1  clock, all logic on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port ifu_araddr  in  ADDR_W  fetch address, word-aligned.
REQ-008 SHALL have port ifu_arvalid  in  1  fetch request, held by the IFU until ifu_rvalid_o.
REQ-009 SHALL have port fence_i  in  1  single-cycle invalidate-all pulse.
REQ-010 SHALL have port ifu_rdata_o  out  DATA_W  instruction word.
REQ-011 SHALL have port ifu_rvalid_o  out  1  one-cycle data-valid strobe.
REQ-012 SHALL have port bus_araddr_o  out  ADDR_W  word address toward the bus arbiter.
REQ-013 SHALL have port bus_arvalid_o  out  1  read request, held until bus_rvalid.
REQ-014 SHALL have port bus_rdata  in  DATA_W  bus read word.
REQ-015 SHALL have port bus_rvalid  in  1  bus read-beat complete.
REQ-016 SHALL have ports hit_cnt_o and miss_cnt_o  out  32  performance counters.

Function
REQ-017 SHALL split the address into offset[log2(WORDS*4)-1:0], index[log2(SETS)], and tag (the remaining upper bits).
REQ-018 SHALL implement the states IDLE, FILL and RESP.
REQ-019 IDLE, ifu_arvalid high, valid[index] set and tag equal: SHALL go to RESP and increment hit_cnt_o.
REQ-020 IDLE, ifu_arvalid high, lookup misses: SHALL latch the address, clear beat to 0, go to FILL, and increment miss_cnt_o.
REQ-021 FILL: SHALL drive bus_arvalid_o=1 with bus_araddr_o = line base + beat*4.
REQ-022 FILL, bus_rvalid high: SHALL write bus_rdata into data[index][beat] and increment beat.
REQ-023 FILL, bus_rvalid high with beat==WORDS-1: SHALL write the tag, set valid[index], and go to RESP; beat SHALL NOT wrap into a fifth request.
REQ-024 RESP: SHALL assert ifu_rvalid_o for exactly one cycle with data[index][word offset] of the latched address, then go to IDLE.
REQ-025 Hit latency SHALL be 1 cycle from request acceptance; miss latency SHALL be WORDS bus transactions + 1 cycle.
REQ-026 ifu_rdata_o SHALL be 0 whenever ifu_rvalid_o is 0.
REQ-027 Outside FILL, bus_arvalid_o SHALL be 0 and bus_araddr_o SHALL be 0.
REQ-028 ifu_arvalid dropping during FILL (redirect): the fill SHALL complete and the line SHALL become valid; RESP SHALL be skipped, returning directly to IDLE.
REQ-029 ifu_arvalid dropping during RESP: the strobe SHALL still be issued and the IFU SHALL ignore it.
REQ-030 fence_i in IDLE or RESP: SHALL clear all valid bits in that cycle.
REQ-031 fence_i during FILL: SHALL clear all valid bits, and the in-progress line SHALL NOT be marked valid; the RESP data SHALL still be delivered.
REQ-032 fence_i simultaneous with a request in IDLE: the request SHALL be treated as a miss.
REQ-033 bus_rvalid outside FILL SHALL be ignored.
REQ-034 Counters SHALL wrap modulo 2^32.

Reset
REQ-035 rst SHALL force state=IDLE, beat=0, all valid bits=0 and both counters=0.
REQ-036 rst SHALL force all outputs to 0 in the same cycle.
REQ-037 Tag and data arrays SHALL NOT be reset.
REQ-038 A reset mid-FILL SHALL abandon the fill; late bus beats SHALL be dropped per REQ-033.

Structure
REQ-039 The state enum and the SETS/WORDS defaults SHALL live in the shared macro/package file, alongside the bus address macros.
REQ-040 The tag/data arrays SHALL be a sub-module icache_direct_array (1 read port, 1 write port, combinational read), so that it can later be replaced by an SRAM macro.

Verification
REQ-041 After reset, fetch 0x30000000 with bus words 0x11,0x22,0x33,0x44 -> 4 bus reads at 0x30000000/04/08/0C, then ifu_rdata_o=0x11, miss_cnt=1.
REQ-042 Then fetch 0x30000008 -> ifu_rvalid_o the next cycle, data 0x33, no bus_arvalid_o, hit_cnt=1.
REQ-043 Fetch 0x30000100 (same index, different tag) -> refill evicts the line; a refetch of 0x30000000 misses again.
REQ-044 fence_i pulse during the beat-2 fill of 0x30000010 -> RESP is delivered; a refetch of 0x30000010 misses.
REQ-045 ifu_arvalid dropped after beat 1 -> no ifu_rvalid_o, line valid, and the next fetch of that line hits.
REQ-046 rst asserted mid-FILL with a bus_rvalid arriving 1 cycle later -> state IDLE, no array write, all outputs 0.
